// File: rtl/spi_image_loader.sv
// spi_image_loader
// Consumes the SPI byte receiver's stream, decodes the LOAD / CLEAR command
// bytes and assembles a packed binary image for the BNN inference core.
// Optional build macro IMG_CHECKSUM_EN: a load carries one extra trailing
// byte that must equal the XOR of all image bytes.
//
// state  | meaning
// IDLE   | waiting for a command byte; receiver enabled
// LOAD   | collecting image bytes (and checksum byte when enabled)
// DONE   | image complete; raises img_valid for one transition
// READY  | image presented to the core; receiver held off until img_ack
module spi_image_loader #(
  parameter int         IMG_BITS       = 1024,
  parameter logic [7:0] CMD_LOAD       = 8'hA5,
  parameter logic [7:0] CMD_CLEAR      = 8'h5A,
  parameter int         TIMEOUT_CYCLES = 100000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7:0]          spi_rx_data,
  input  logic                byte_valid,
  output logic                byte_taken,
  output logic                rx_enable,
  output logic [IMG_BITS-1:0] img_bits,
  output logic                img_valid,
  input  logic                img_ack,
  output logic                load_err
);

  localparam int IMG_BYTES = IMG_BITS / 8;
  localparam int CNT_W     = $clog2(IMG_BYTES + 1);
  localparam int IDX_W     = $clog2(IMG_BITS);
  localparam int TO_W      = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DONE  = 2'd2,
    S_READY = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              byte_valid_q;
  logic              accept;
  logic [7:0]        rev_byte;
  logic [CNT_W-1:0]  byte_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic [IDX_W-1:0]  bit_base;
  logic              data_phase;
  logic              load_end;
  logic              chk_ok;
  logic              timeout_hit;
  logic              rx_enable_d;

  // Edge-based acceptance: a lingering byte_valid never yields a second byte.
  assign accept      = byte_valid & ~byte_valid_q & rx_enable;
  assign bit_base    = IDX_W'(byte_cnt) << 3;
  assign data_phase  = byte_cnt < CNT_W'(IMG_BYTES);
  assign timeout_hit = to_cnt == TO_W'(TIMEOUT_CYCLES - 1);

`ifdef IMG_CHECKSUM_EN
  logic [7:0] chk_acc;
  // The load ends on the trailing checksum byte, after all image bytes.
  assign load_end = ~data_phase;
  assign chk_ok   = spi_rx_data == chk_acc;
`else
  assign load_end = byte_cnt == CNT_W'(IMG_BYTES - 1);
  assign chk_ok   = 1'b1;
`endif

  // Byte bit 7 is the first pixel of its group of eight.
  always_comb begin
    rev_byte = '0;
    for (int i = 0; i < 8; i++) rev_byte[i] = spi_rx_data[7-i];
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode; an accepted byte takes priority over a timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept && spi_rx_data == CMD_LOAD) state_d = S_LOAD;
      S_LOAD: begin
        if (accept) begin
          if (load_end) state_d = chk_ok ? S_DONE : S_IDLE;
        end else if (timeout_hit) begin
          state_d = S_IDLE;
        end
      end
      S_DONE:  state_d = S_READY;
      S_READY: if (img_ack) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Receiver is enabled only in states that can absorb a byte.
  always_comb begin
    rx_enable_d = 1'b0;
    if (state_d == S_IDLE || state_d == S_LOAD) rx_enable_d = 1'b1;
  end

  // Datapath: edge register, handshake, image buffer, counters and flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_valid_q <= 1'b0;
      byte_taken   <= 1'b0;
      rx_enable    <= 1'b0;
      img_bits     <= '0;
      img_valid    <= 1'b0;
      load_err     <= 1'b0;
      byte_cnt     <= '0;
      to_cnt       <= '0;
`ifdef IMG_CHECKSUM_EN
      chk_acc      <= '0;
`endif
    end else begin
      byte_valid_q <= byte_valid;
      byte_taken   <= accept;
      rx_enable    <= rx_enable_d;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (spi_rx_data == CMD_LOAD) begin
              byte_cnt  <= '0;
              to_cnt    <= '0;
              load_err  <= 1'b0;
              img_valid <= 1'b0;
`ifdef IMG_CHECKSUM_EN
              chk_acc   <= '0;
`endif
            end else if (spi_rx_data == CMD_CLEAR) begin
              img_bits  <= '0;
              img_valid <= 1'b0;
            end
          end
        end
        S_LOAD: begin
          if (accept) begin
            to_cnt <= '0;
            if (data_phase) begin
              img_bits[bit_base +: 8] <= rev_byte;
              byte_cnt                <= byte_cnt + CNT_W'(1);
`ifdef IMG_CHECKSUM_EN
              chk_acc                 <= chk_acc ^ spi_rx_data;
`endif
            end
            if (load_end && !chk_ok) load_err <= 1'b1;
          end else if (timeout_hit) begin
            load_err <= 1'b1;
            to_cnt   <= '0;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        S_DONE:  img_valid <= 1'b1;
        S_READY: if (img_ack) img_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_image_loader.sv
// Directed bench for spi_image_loader with a small image-buffer model.
// Build with +define+IMG_CHECKSUM_EN to exercise the checksum variant.
module tb_spi_image_loader;

  localparam int         IMG_BITS  = 1024;
  localparam int         IMG_BYTES = IMG_BITS / 8;
  localparam int         TIMEOUT   = 300;
  localparam logic [7:0] CMD_LOAD  = 8'hA5;
  localparam logic [7:0] CMD_CLEAR = 8'h5A;

  logic                clk = 1'b0;
  logic                rst_n = 1'b1;
  logic [7:0]          spi_rx_data = '0;
  logic                byte_valid = 1'b0;
  logic                byte_taken;
  logic                rx_enable;
  logic [IMG_BITS-1:0] img_bits;
  logic                img_valid;
  logic                img_ack = 1'b0;
  logic                load_err;

  logic [IMG_BITS-1:0] exp_img = '0;
  int                  checks = 0;
  int                  failures = 0;
  int                  taken_cnt = 0;

  spi_image_loader #(
    .IMG_BITS       (IMG_BITS),
    .CMD_LOAD       (CMD_LOAD),
    .CMD_CLEAR      (CMD_CLEAR),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .spi_rx_data (spi_rx_data),
    .byte_valid  (byte_valid),
    .byte_taken  (byte_taken),
    .rx_enable   (rx_enable),
    .img_bits    (img_bits),
    .img_valid   (img_valid),
    .img_ack     (img_ack),
    .load_err    (load_err)
  );

  always #5 clk = ~clk;

  // Pulse counter for byte_taken, sampled mid-cycle.
  always @(negedge clk) if (byte_taken) taken_cnt++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  function automatic logic [7:0] pat_byte(input int p, input int k);
    logic [7:0] kb;
    kb = 8'(k);
    case (p)
      0:       return kb;
      1:       return 8'hFF - kb;
      2:       return 8'h01;
      default: return kb + 8'h01;
    endcase
  endfunction

  // Receiver-like byte: valid for three cycles, then low for one.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    spi_rx_data = b;
    byte_valid  = 1'b1;
    repeat (3) @(negedge clk);
    byte_valid = 1'b0;
    @(negedge clk);
  endtask

  // Final byte of a load, with cycle-exact checks around DONE.
  task automatic send_last(input logic [7:0] b, input logic ok);
    @(negedge clk);
    spi_rx_data = b;
    byte_valid  = 1'b1;
    @(negedge clk);
    check("last_taken", 64'(byte_taken), 64'(1'b1));
    check("valid_at_last_take", 64'(img_valid), 64'(1'b0));
    @(negedge clk);
    if (ok) begin
      check("valid_after_done", 64'(img_valid), 64'(1'b1));
      check("rx_en_ready", 64'(rx_enable), 64'(1'b0));
    end else begin
      check("chk_err", 64'(load_err), 64'(1'b1));
      check("chk_valid_low", 64'(img_valid), 64'(1'b0));
      check("chk_rx_en", 64'(rx_enable), 64'(1'b1));
    end
    byte_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic load_image(input int p, input logic ok);
    int t0;
    logic [7:0] b, x;
    t0 = taken_cnt;
    x  = '0;
    send_byte(CMD_LOAD);
    check("load_err_cleared", 64'(load_err), 64'(1'b0));
    for (int k = 0; k < IMG_BYTES - 1; k++) begin
      b = pat_byte(p, k);
      x ^= b;
      exp_img[8*k +: 8] = rev8(b);
      send_byte(b);
    end
    b = pat_byte(p, IMG_BYTES - 1);
    x ^= b;
    exp_img[8*(IMG_BYTES-1) +: 8] = rev8(b);
`ifdef IMG_CHECKSUM_EN
    send_byte(b);
    send_last(ok ? x : (x ^ 8'h01), ok);
    check("taken_count", 64'(taken_cnt - t0), 64'(IMG_BYTES + 2));
`else
    send_last(b, ok);
    check("taken_count", 64'(taken_cnt - t0), 64'(IMG_BYTES + 1));
`endif
    check("img_contents", 64'(img_bits == exp_img), 64'(1'b1));
  endtask

  task automatic ack_image();
    @(negedge clk);
    img_ack = 1'b1;
    @(negedge clk);
    img_ack = 1'b0;
    check("ack_valid_low", 64'(img_valid), 64'(1'b0));
    check("ack_rx_en", 64'(rx_enable), 64'(1'b1));
    check("ack_img_held", 64'(img_bits == exp_img), 64'(1'b1));
  endtask

  initial begin
    int t0;

    #1 rst_n = 1'b0;
    #1;
    check("rst_taken", 64'(byte_taken), 64'(1'b0));
    check("rst_rx_en", 64'(rx_enable), 64'(1'b0));
    check("rst_valid", 64'(img_valid), 64'(1'b0));
    check("rst_err", 64'(load_err), 64'(1'b0));
    check("rst_img", 64'(img_bits == '0), 64'(1'b1));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_rx_en", 64'(rx_enable), 64'(1'b1));

    // Non-command byte in IDLE, held two cycles: one pulse, no effect.
    t0 = taken_cnt;
    @(negedge clk);
    spi_rx_data = 8'h33;
    byte_valid  = 1'b1;
    repeat (2) @(negedge clk);
    byte_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("junk_one_pulse", 64'(taken_cnt - t0), 64'(1));
    check("junk_no_valid", 64'(img_valid), 64'(1'b0));

    // Ramp image 0x00..0x7F.
    load_image(0, 1'b1);
    check("byte0", 64'(img_bits[7:0]), 64'(8'h00));
    check("byte1", 64'(img_bits[15:8]), 64'(8'h80));
    check("byte127", 64'(img_bits[1023:1016]), 64'(8'hFE));

    // Bytes in READY are not accepted.
    t0 = taken_cnt;
    send_byte(8'h77);
    check("ready_no_take", 64'(taken_cnt - t0), 64'(0));
    check("ready_valid_held", 64'(img_valid), 64'(1'b1));
    check("ready_img_held", 64'(img_bits == exp_img), 64'(1'b1));

    ack_image();

    // CLEAR from IDLE.
    send_byte(CMD_CLEAR);
    exp_img = '0;
    check("clear_img", 64'(img_bits == '0), 64'(1'b1));
    check("clear_valid", 64'(img_valid), 64'(1'b0));

    // Timeout after ten data bytes.
    send_byte(CMD_LOAD);
    for (int k = 0; k < 10; k++) begin
      exp_img[8*k +: 8] = rev8(pat_byte(3, k));
      send_byte(pat_byte(3, k));
    end
    repeat (TIMEOUT - 4) @(negedge clk);
    check("to_not_yet", 64'(load_err), 64'(1'b0));
    @(negedge clk);
    check("to_err", 64'(load_err), 64'(1'b1));
    check("to_valid", 64'(img_valid), 64'(1'b0));
    check("to_rx_en", 64'(rx_enable), 64'(1'b1));
    check("to_partial_kept", 64'(img_bits == exp_img), 64'(1'b1));

    // New load clears the error; reset while byte 51 is being taken.
    send_byte(CMD_LOAD);
    check("reload_err_clear", 64'(load_err), 64'(1'b0));
    for (int k = 0; k < 50; k++) begin
      exp_img[8*k +: 8] = rev8(pat_byte(1, k));
      send_byte(pat_byte(1, k));
    end
    check("midload_img", 64'(img_bits == exp_img), 64'(1'b1));
    @(negedge clk);
    spi_rx_data = pat_byte(1, 50);
    byte_valid  = 1'b1;
    @(negedge clk);
    check("midload_taken", 64'(byte_taken), 64'(1'b1));
    rst_n = 1'b0;
    #1;
    exp_img = '0;
    check("mrst_taken", 64'(byte_taken), 64'(1'b0));
    check("mrst_rx_en", 64'(rx_enable), 64'(1'b0));
    check("mrst_valid", 64'(img_valid), 64'(1'b0));
    check("mrst_err", 64'(load_err), 64'(1'b0));
    check("mrst_img", 64'(img_bits == '0), 64'(1'b1));
    byte_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    load_image(1, 1'b1);
    check("inv_byte0", 64'(img_bits[7:0]), 64'(8'hFF));
    check("inv_byte1", 64'(img_bits[15:8]), 64'(8'h7F));
    ack_image();

`ifdef IMG_CHECKSUM_EN
    load_image(2, 1'b1);
    ack_image();
    load_image(2, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
